// File: rtl/dff_chain_error_counter_pkg.sv
// -----------------------------------------------------------------------------
// dff_chain_error_counter_pkg
// Shared definitions for the DFF-chain error counter:
//   - CNT_W_DEF   : default error counter width
//   - pattern_e   : test pattern encodings driven on pattern_mode
//   - state_e     : control FSM states
//   - PRBS7_SEED  : PRBS7 register value after reset / on leaving IDLE
//   - prbs7_next  : one step of the x^7+x^6+1 generator (shift left)
// -----------------------------------------------------------------------------
package dff_chain_error_counter_pkg;

   localparam int CNT_W_DEF = 12;

   typedef enum logic [1:0] {
      PAT_ZERO  = 2'd0,
      PAT_ONE   = 2'd1,
      PAT_CHECK = 2'd2,
      PAT_PRBS7 = 2'd3
   } pattern_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      CHECK = 2'd2,
      SAVE  = 2'd3
   } state_e;

   localparam logic [6:0] PRBS7_SEED = 7'h7F;

   // Shift left; the new LSB is the feedback of taps 7 and 6.
   function automatic logic [6:0] prbs7_next(input logic [6:0] q);
      return {q[5:0], q[6] ^ q[5]};
   endfunction

endpackage

// File: rtl/dff_chain_error_counter_sat_counter.sv
// -----------------------------------------------------------------------------
// dff_chain_error_counter_sat_counter
// One saturating error counter.
//   clk     : clock
//   reset_n : synchronous active-low reset, zeroes the count
//   clr     : synchronous clear; dominates inc, also when saturated
//   inc     : add one unless already at all-ones
//   count   : current count, holds at 2^CNT_W-1
// -----------------------------------------------------------------------------
module dff_chain_error_counter_sat_counter
   import dff_chain_error_counter_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/dff_chain_error_counter.sv
// -----------------------------------------------------------------------------
// dff_chain_error_counter
// Drives a test pattern into the DUT DFF chains, compares each synchronised
// chain output against a delayed copy of the pattern and keeps one saturating
// error count per chain. Every WINDOW checked cycles a two-cycle save_data
// strobe tells the downstream output stage to snapshot the counts.
//
// Ports:
//   data_clk      : single clock for all logic
//   reset_n       : synchronous active-low reset
//   run           : 1 = test active, 0 = back to IDLE on the next cycle
//   pattern_mode  : pattern select, sampled only while IDLE (pattern_e)
//   clear_on_save : zero all counters on the cycle after save_data falls
//   chain_out     : raw chain outputs (asynchronous to us, synchronised here)
//   dff_in        : registered pattern bit fed to every chain input
//   error_count   : chain i count in bits [i*CNT_W +: CNT_W]
//   save_data     : snapshot strobe, high for two cycles per window
//   busy          : high whenever the FSM is not IDLE
//
// Handshake: save_data is a plain strobe with no back-pressure; the
// downstream stage captures error_count on its rising edge. The counts keep
// moving while it is high.
// -----------------------------------------------------------------------------
module dff_chain_error_counter
   import dff_chain_error_counter_pkg::*;
#(
   parameter int NUM_CHAINS  = 10,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int CHAIN_LEN   = 64,
   parameter int SYNC_STAGES = 2,
   parameter int WINDOW      = 1000000
) (
   input  logic                        data_clk,
   input  logic                        reset_n,
   input  logic                        run,
   input  logic [1:0]                  pattern_mode,
   input  logic                        clear_on_save,
   input  logic [NUM_CHAINS-1:0]       chain_out,
   output logic                        dff_in,
   output logic [NUM_CHAINS*CNT_W-1:0] error_count,
   output logic                        save_data,
   output logic                        busy
);

   // Expected-data delay: chain latency plus the synchroniser.
   localparam int DLY_LEN  = CHAIN_LEN + SYNC_STAGES;
   // One extra fill cycle covers the registered mismatch stage.
   localparam int FILL_LEN = DLY_LEN + 1;
   localparam int FILL_W   = $clog2(FILL_LEN + 1);
   localparam int WIN_W    = $clog2(WINDOW + 1);

   state_e              state;
   state_e              state_nxt;
   logic [FILL_W-1:0]   fill_cnt;
   logic [WIN_W-1:0]    win_cnt;
   logic                save_cnt;

   pattern_e            mode_q;
   logic [6:0]          prbs_q;
   logic                chk_q;
   logic                pat_bit;

   logic [DLY_LEN-1:0]  dly_q;
   logic                expected;
   logic [NUM_CHAINS-1:0] sync_q [SYNC_STAGES];
   logic [NUM_CHAINS-1:0] mismatch_q;
   logic                cmp_en;
   logic                clr;

   // ---------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge data_clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (run) state_nxt = FILL;
         end
         FILL: begin
            if (!run)                                   state_nxt = IDLE;
            else if (fill_cnt == FILL_W'(FILL_LEN - 1)) state_nxt = CHECK;
         end
         CHECK: begin
            if (!run)                               state_nxt = IDLE;
            else if (win_cnt == WIN_W'(WINDOW - 1)) state_nxt = SAVE;
         end
         SAVE: begin
            if (!run)          state_nxt = IDLE;
            else if (save_cnt) state_nxt = CHECK;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Each phase counter runs only in its own state and restarts from zero
   // every time that state is entered.
   always_ff @(posedge data_clk) begin
      if (!reset_n) begin
         fill_cnt <= '0;
         win_cnt  <= '0;
         save_cnt <= 1'b0;
      end else begin
         fill_cnt <= (state == FILL)  ? fill_cnt + FILL_W'(1) : '0;
         win_cnt  <= (state == CHECK) ? win_cnt + WIN_W'(1)   : '0;
         save_cnt <= (state == SAVE)  ? ~save_cnt             : 1'b0;
      end
   end

   // Gated with run so the strobe drops the moment the test is aborted.
   assign save_data = (state == SAVE) && run;
   assign busy      = (state != IDLE);

   // ---------------------------------------------------------------------
   // Pattern generator: held at its start point in IDLE so every run begins
   // with the same sequence; the mode is latched only while IDLE.
   // ---------------------------------------------------------------------
   always_comb begin
      pat_bit = 1'b0;
      case (mode_q)
         PAT_ZERO:  pat_bit = 1'b0;
         PAT_ONE:   pat_bit = 1'b1;
         PAT_CHECK: pat_bit = chk_q;
         PAT_PRBS7: pat_bit = prbs_q[6];
         default:   pat_bit = 1'b0;
      endcase
   end

   always_ff @(posedge data_clk) begin
      if (!reset_n) begin
         mode_q <= PAT_ZERO;
         prbs_q <= PRBS7_SEED;
         chk_q  <= 1'b0;
         dff_in <= 1'b0;
      end else if (state == IDLE) begin
         mode_q <= pattern_e'(pattern_mode);
         prbs_q <= PRBS7_SEED;
         chk_q  <= 1'b0;
         dff_in <= 1'b0;
      end else begin
         prbs_q <= prbs7_next(prbs_q);
         chk_q  <= ~chk_q;
         dff_in <= pat_bit;
      end
   end

   // ---------------------------------------------------------------------
   // Expected data and synchronisers. The delay-line tail carries the
   // dff_in value that the ideal chain presents at the synchroniser output
   // in the same cycle.
   // ---------------------------------------------------------------------
   always_ff @(posedge data_clk) begin
      if (!reset_n) begin
         dly_q <= '0;
      end else begin
         dly_q <= {dly_q[DLY_LEN-2:0], dff_in};
      end
   end

   assign expected = dly_q[DLY_LEN-1];

   always_ff @(posedge data_clk) begin
      if (!reset_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= chain_out;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   // ---------------------------------------------------------------------
   // Compare and count. The enable gates both the mismatch register and the
   // increment so nothing leaks into the counts during FILL or IDLE.
   // ---------------------------------------------------------------------
   assign cmp_en = (state == CHECK) || (state == SAVE);

   always_ff @(posedge data_clk) begin
      if (!reset_n) begin
         mismatch_q <= '0;
      end else begin
         mismatch_q <= (sync_q[SYNC_STAGES-1] ^ {NUM_CHAINS{expected}})
                       & {NUM_CHAINS{cmp_en}};
      end
   end

   // Clear lands on the edge that ends SAVE, so the counts read zero in the
   // first cycle with save_data low. An abort at that edge keeps the counts.
   assign clr = (state == SAVE) && save_cnt && run && clear_on_save;

   for (genvar i = 0; i < NUM_CHAINS; i++) begin : g_cnt
      dff_chain_error_counter_sat_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk     (data_clk),
         .reset_n (reset_n),
         .clr     (clr),
         .inc     (mismatch_q[i] && cmp_en),
         .count   (error_count[i*CNT_W +: CNT_W])
      );
   end

endmodule
